// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester memory arbiter: FSM and owner encodings, default widths.
// No logic; latency n/a.
// Backpressure n/a.
package mem_arb_pkg;

    localparam int MEM_ARB_ADDR_W = 16;
    localparam int MEM_ARB_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        RESP  = 2'b10
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between CPU and DMA requests (MEM_ARB_RR_EN selects round-robin ties).
// Latency: combinational, zero cycles.
// Backpressure: none; the caller samples grant_dma only when it is free to start an access.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic cpu_req,
    input  logic dma_req,
    input  logic last_grant,
    output logic grant_dma
);

`ifdef MEM_ARB_RR_EN
    // On a tie the requester that did not win last time gets the grant.
    assign grant_dma = dma_req & (~cpu_req | (last_grant == OWN_CPU));
`else
    // Fixed priority: CPU always wins a tie, so the last-grant history is not needed.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign grant_dma         = dma_req & ~cpu_req;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (CPU, DMA) single-port memory arbiter; MEM_ARB_RR_EN enables round-robin ties.
// Latency: request seen in IDLE at edge N -> mem_en in cycle N+1, ack + rdata in cycle N+2.
// Backpressure: requesters hold req until their one-cycle ack; one access per three cycles.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = MEM_ARB_ADDR_W,
    parameter int DATA_W = MEM_ARB_DATA_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t state_q, state_d;
    owner_t owner_q, owner_d;
    owner_t last_grant_q, last_grant_d;
    logic   grant_dma;

    mem_arb_pick u_pick (
        .cpu_req    (cpu_req),
        .dma_req    (dma_req),
        .last_grant (last_grant_q),
        .grant_dma  (grant_dma)
    );

    // State, owner and tie-break history; last grant starts at DMA so CPU wins the first tie.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= IDLE;
            owner_q      <= OWN_CPU;
            last_grant_q <= OWN_DMA;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next state and all outputs; everything is zero unless the current state drives it.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        cpu_ack      = 1'b0;
        cpu_rdata    = '0;
        dma_ack      = 1'b0;
        dma_rdata    = '0;
        case (state_q)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    owner_d      = grant_dma ? OWN_DMA : OWN_CPU;
                    last_grant_d = grant_dma ? OWN_DMA : OWN_CPU;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                // The transaction is committed: a dropped req no longer matters.
                mem_en = 1'b1;
                if (owner_q == OWN_DMA) begin
                    mem_we    = dma_we;
                    mem_addr  = dma_addr;
                    mem_wdata = dma_wdata;
                end else begin
                    mem_we    = cpu_we;
                    mem_addr  = cpu_addr;
                    mem_wdata = cpu_wdata;
                end
                state_d = RESP;
            end
            RESP: begin
                if (owner_q == OWN_DMA) begin
                    dma_ack   = 1'b1;
                    dma_rdata = mem_rdata;
                end else begin
                    cpu_ack   = 1'b1;
                    cpu_rdata = mem_rdata;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, CPU read, DMA write, tie arbitration, dropped request.
// Small synchronous memory model answers mem_en one cycle later.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_mem_arbiter;

    logic        CLK;
    logic        RST;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [15:0] cpu_rdata, dma_rdata;
    logic        cpu_ack, dma_ack;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    logic [15:0] mem [0:255];

    int n_cmp  = 0;
    int n_fail = 0;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .dma_req   (dma_req),
        .dma_we    (dma_we),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_rdata (dma_rdata),
        .dma_ack   (dma_ack),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Synchronous memory: read-before-write, data valid the cycle after mem_en.
    always @(posedge CLK) begin
        if (mem_en) begin
            mem_rdata <= mem[mem_addr[7:0]];
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        end
    end

    task automatic test_reset();
        RST = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
        #2;
        n_cmp++; if ({mem_en, mem_we, cpu_ack, dma_ack} !== 4'b0000) begin n_fail++; $display("FAIL reset_ctl: got %b want 0000", {mem_en, mem_we, cpu_ack, dma_ack}); end
        n_cmp++; if ({mem_addr, mem_wdata, cpu_rdata, dma_rdata} !== 64'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, cpu_rdata, dma_rdata}); end
        @(negedge CLK);
        RST = 1'b1;
        cpu_req = 1'b1; cpu_addr = 16'h0040;
        @(negedge CLK);
        n_cmp++; if (mem_en !== 1'b1) begin n_fail++; $display("FAIL reset_pre_issue: mem_en got %b want 1", mem_en); end
        #1 RST = 1'b0;
        #1;
        n_cmp++; if ({mem_en, mem_we, cpu_ack, dma_ack} !== 4'b0000) begin n_fail++; $display("FAIL reset_mid_ctl: got %b want 0000", {mem_en, mem_we, cpu_ack, dma_ack}); end
        n_cmp++; if ({mem_addr, mem_wdata, cpu_rdata, dma_rdata} !== 64'h0) begin n_fail++; $display("FAIL reset_mid_data: got %h want 0", {mem_addr, mem_wdata, cpu_rdata, dma_rdata}); end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            n_cmp++; if ({mem_en, cpu_ack} !== 2'b00) begin n_fail++; $display("FAIL reset_hold_%0d: en/ack got %b want 00", i, {mem_en, cpu_ack}); end
        end
        cpu_req = 1'b0; cpu_addr = 16'h0000;
        RST = 1'b1;
        @(negedge CLK);
        n_cmp++; if ({mem_en, cpu_ack, dma_ack} !== 3'b000) begin n_fail++; $display("FAIL reset_release: got %b want 000", {mem_en, cpu_ack, dma_ack}); end
    endtask

    task automatic test_cpu_read();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
        @(negedge CLK);
        n_cmp++; if ({mem_en, mem_we} !== 2'b10) begin n_fail++; $display("FAIL cpu_rd_issue_ctl: got %b want 10", {mem_en, mem_we}); end
        n_cmp++; if (mem_addr !== 16'h0040) begin n_fail++; $display("FAIL cpu_rd_issue_addr: got %h want 0040", mem_addr); end
        n_cmp++; if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL cpu_rd_early_ack: got %b want 0", cpu_ack); end
        @(negedge CLK);
        n_cmp++; if ({cpu_ack, dma_ack, mem_en} !== 3'b100) begin n_fail++; $display("FAIL cpu_rd_resp_ctl: got %b want 100", {cpu_ack, dma_ack, mem_en}); end
        n_cmp++; if (cpu_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL cpu_rd_data: got %h want beef", cpu_rdata); end
        n_cmp++; if (dma_rdata !== 16'h0000) begin n_fail++; $display("FAIL cpu_rd_dma_rdata: got %h want 0000", dma_rdata); end
        cpu_req = 1'b0; cpu_addr = 16'h0000;
        @(negedge CLK);
        n_cmp++; if ({cpu_ack, mem_en, cpu_rdata} !== 18'h0) begin n_fail++; $display("FAIL cpu_rd_idle: got %h want 0", {cpu_ack, mem_en, cpu_rdata}); end
    endtask

    task automatic test_dma_write();
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0100; dma_wdata = 16'h1234;
        @(negedge CLK);
        n_cmp++; if ({mem_en, mem_we} !== 2'b11) begin n_fail++; $display("FAIL dma_wr_issue_ctl: got %b want 11", {mem_en, mem_we}); end
        n_cmp++; if (mem_addr !== 16'h0100) begin n_fail++; $display("FAIL dma_wr_addr: got %h want 0100", mem_addr); end
        n_cmp++; if (mem_wdata !== 16'h1234) begin n_fail++; $display("FAIL dma_wr_wdata: got %h want 1234", mem_wdata); end
        @(negedge CLK);
        n_cmp++; if ({dma_ack, cpu_ack} !== 2'b10) begin n_fail++; $display("FAIL dma_wr_ack: got %b want 10", {dma_ack, cpu_ack}); end
        n_cmp++; if (dma_rdata !== 16'h0000) begin n_fail++; $display("FAIL dma_wr_rdata: got %h want 0000", dma_rdata); end
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 0; dma_wdata = 0;
        @(negedge CLK);
        n_cmp++; if (mem[8'h00] !== 16'h1234) begin n_fail++; $display("FAIL dma_wr_stored: got %h want 1234", mem[8'h00]); end
        n_cmp++; if ({dma_ack, mem_en} !== 2'b00) begin n_fail++; $display("FAIL dma_wr_idle: got %b want 00", {dma_ack, mem_en}); end
    endtask

    task automatic test_tie();
        logic [3:0] order;
        logic [3:0] exp_order;
        int acks;
        int cpu_n;
        int dma_n;
`ifdef MEM_ARB_RR_EN
        exp_order = 4'b1010;
`else
        exp_order = 4'b0000;
`endif
        order = 4'b0000; acks = 0; cpu_n = 0; dma_n = 0;
        cpu_req = 1'b1; cpu_addr = 16'h0040;
        dma_req = 1'b1; dma_addr = 16'h0002;
        for (int cyc = 0; cyc < 16 && acks < 4; cyc++) begin
            @(negedge CLK);
            if (cpu_ack && dma_ack) begin
                n_cmp++; n_fail++; $display("FAIL tie_double_ack: cycle %0d got both acks want one", cyc);
            end
            if (cpu_ack || dma_ack) begin
                order[acks] = dma_ack;
                if (dma_ack) dma_n++; else cpu_n++;
                acks++;
            end
        end
        cpu_req = 1'b0; dma_req = 1'b0; cpu_addr = 0; dma_addr = 0;
        n_cmp++; if (acks !== 4) begin n_fail++; $display("FAIL tie_count: got %0d acks want 4", acks); end
        n_cmp++; if (order !== exp_order) begin n_fail++; $display("FAIL tie_order: got %b want %b (bit i = 1 for DMA)", order, exp_order); end
        n_cmp++; if (cpu_n !== 4 - $countones(exp_order)) begin n_fail++; $display("FAIL tie_cpu_acks: got %0d want %0d", cpu_n, 4 - $countones(exp_order)); end
        n_cmp++; if (dma_n !== $countones(exp_order)) begin n_fail++; $display("FAIL tie_dma_acks: got %0d want %0d", dma_n, $countones(exp_order)); end
        @(negedge CLK);
        n_cmp++; if ({mem_en, cpu_ack, dma_ack} !== 3'b000) begin n_fail++; $display("FAIL tie_idle: got %b want 000", {mem_en, cpu_ack, dma_ack}); end
    endtask

    task automatic test_drop();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
        @(negedge CLK);
        n_cmp++; if (mem_en !== 1'b1) begin n_fail++; $display("FAIL drop_issue: mem_en got %b want 1", mem_en); end
        cpu_req = 1'b0;
        @(negedge CLK);
        n_cmp++; if (cpu_ack !== 1'b1) begin n_fail++; $display("FAIL drop_ack: got %b want 1", cpu_ack); end
        n_cmp++; if (cpu_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL drop_rdata: got %h want beef", cpu_rdata); end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            n_cmp++; if ({mem_en, cpu_ack} !== 2'b00) begin n_fail++; $display("FAIL drop_after_%0d: en/ack got %b want 00", i, {mem_en, cpu_ack}); end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h40] = 16'hBEEF;
        mem[8'h02] = 16'h5A5A;
        mem_rdata  = 16'h0000;
        test_reset();
        test_cpu_read();
        test_dma_write();
        test_tie();
        test_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL provide parameters (name, default, meaning): ADDR_W, 16, memory address width; DATA_W, 16, memory data width.
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 CLK  input  1  rising-edge clock.
REQ-004 RST  input  1  asynchronous active-low reset.
REQ-005 cpu_req  input  1  CPU datapath memory request; held until cpu_ack.
REQ-006 cpu_we  input  1  CPU write (1) / read (0).
REQ-007 cpu_addr  input  ADDR_W  CPU address.
REQ-008 cpu_wdata  input  DATA_W  CPU write data.
REQ-009 cpu_rdata  output  DATA_W  CPU read data; valid only while cpu_ack=1.
REQ-010 cpu_ack  output  1  one-cycle completion pulse to CPU.
REQ-011 dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ack SHALL mirror REQ-005..REQ-010 for the DMA/loader requester.
REQ-012 mem_en  output  1  memory access strobe.
REQ-013 mem_we  output  1  memory write enable, qualified by mem_en.
REQ-014 mem_addr  output  ADDR_W  memory address.
REQ-015 mem_wdata  output  DATA_W  memory write data.
REQ-016 mem_rdata  input  DATA_W  synchronous memory read data, valid one cycle after mem_en.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, RESP with registered owner (CPU/DMA).
REQ-018 IDLE: no request -> stay IDLE; any request -> latch owner, go ISSUE.
REQ-019 ISSUE: mem_en=1; mem_we, mem_addr, mem_wdata driven from owner's inputs; go RESP.
REQ-020 RESP: owner's ack=1, owner's rdata=mem_rdata; go IDLE unconditionally.
REQ-021 Latency: request sampled in IDLE at edge N -> ack asserted in cycle N+2; max throughput one access per 3 cycles.
REQ-022 Non-owner ack SHALL be 0; non-owner rdata SHALL be 0; rdata of both SHALL be 0 outside RESP.
REQ-023 Outside ISSUE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-024 Simultaneous requests in IDLE: selection per REQ-031/REQ-032.
REQ-025 Requester dropping req during ISSUE/RESP: transaction completes, ack still pulsed; no abort.
REQ-026 Requester still asserting req in the RESP cycle: treated as a new request at next IDLE.
REQ-027 Write transactions SHALL ack in RESP identically to reads; rdata value is don't-care but SHALL equal mem_rdata.

Reset
REQ-028 RST=0 SHALL immediately force state IDLE, owner=CPU, all outputs 0, regardless of clock.
REQ-029 Reset mid-ISSUE or mid-RESP SHALL abandon the transaction with no ack; the requester re-requests.
REQ-030 First edge after RST release SHALL be treated as IDLE evaluation.

Configuration
REQ-031 Without MEM_ARB_RR_EN: fixed priority, CPU wins every simultaneous request; DMA may starve.
REQ-032 With MEM_ARB_RR_EN: round-robin; on simultaneous request, the requester not granted last wins; last-grant register resets to DMA so CPU wins first tie; single requests always granted.

Structure
REQ-033 Shared package mem_arb_pkg SHALL hold state encoding (IDLE=2'b00, ISSUE=2'b01, RESP=2'b10), owner encoding (CPU=0, DMA=1), default ADDR_W/DATA_W.
REQ-034 One sub-module, mem_arb_pick (combinational grant selection from cpu_req, dma_req, last-grant, macro), is natural; the FSM and muxing stay in mem_arbiter.
REQ-035 Unused state encoding 2'b11 SHALL return to IDLE with all outputs 0.

Verification
REQ-036 Reset: RST=0 mid-ISSUE of CPU read -> mem_en=0, cpu_ack never pulses, all outputs 0 within same cycle.
REQ-037 CPU read: cpu_req=1, cpu_addr=16'h0040, mem returns 16'hBEEF -> mem_en=1/mem_addr=16'h0040 at N+1, cpu_ack=1/cpu_rdata=16'hBEEF at N+2.
REQ-038 DMA write: dma_req=1, dma_we=1, dma_addr=16'h0100, dma_wdata=16'h1234 -> mem_en=1, mem_we=1, mem_wdata=16'h1234 at N+1; dma_ack at N+2; cpu_ack stays 0.
REQ-039 Tie, no macro: both requesters held for 4 transactions -> 4 CPU acks, 0 DMA acks.
REQ-040 Tie, MEM_ARB_RR_EN: both held for 4 transactions -> ack order CPU, DMA, CPU, DMA.
REQ-041 Drop: cpu_req deasserted in ISSUE cycle -> cpu_ack still pulses at N+2; arbiter returns to IDLE, no further mem_en.
